// File: rtl/tx_header_fsm_pkg.sv
// Shared completion-TLP definitions for the tx/rx header FSMs.
//   - tx_state_e   : tx header FSM state encodings
//   - CPL / CPLD   : fmt/type byte of DW0 for completions without/with data
//   - cpl_status_e : completion status codes
//   - cpl_req_t    : completion request fields latched on cpl_start
//   - hdr_dw0/1/2  : header DW assembly from a latched request
package tx_header_fsm_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StHdr2    = 3'd1,
    StDataLo  = 3'd2,
    StDataHi  = 3'd3,
    StDataOdd = 3'd4
  } tx_state_e;

  localparam logic [7:0] CPL  = 8'h0A;
  localparam logic [7:0] CPLD = 8'h4A;

  typedef enum logic [2:0] {
    SC = 3'b000,
    UR = 3'b001,
    CA = 3'b100
  } cpl_status_e;

  typedef struct packed {
    cpl_status_e status;
    logic [9:0]  len;
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic [6:0]  lower_addr;
    logic [15:0] completer_id;
  } cpl_req_t;

  // Payload length in DW; a zero length field means 1024.
  function automatic logic [10:0] len_eff(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

  // len*4 - lower_addr[1:0] modulo 4096. A zero len field already reads as
  // 1024*4 = 4096 = 0 modulo 4096, so no special case is needed.
  function automatic logic [11:0] byte_count(input logic [9:0] len, input logic [1:0] lower);
    return {len, 2'b00} - {10'b0, lower};
  endfunction

  // TC, attr, TD and EP are all zero for completions.
  function automatic logic [31:0] hdr_dw0(input cpl_req_t req);
    logic cpld;
    cpld = (req.status == SC);
    return {(cpld ? CPLD : CPL), 14'b0, (cpld ? req.len : 10'd0)};
  endfunction

  // BCM is always zero.
  function automatic logic [31:0] hdr_dw1(input cpl_req_t req);
    return {req.completer_id, req.status, 1'b0, byte_count(req.len, req.lower_addr[1:0])};
  endfunction

  function automatic logic [31:0] hdr_dw2(input cpl_req_t req);
    return {req.requester_id, req.tag, 1'b0, req.lower_addr};
  endfunction

endpackage

// File: rtl/tx_header_fsm_if.sv
// Completion request, read-data handshake and 64-bit AXI4-Stream signals of
// the tx header FSM.
//   master : the FSM side (drives cpl_busy, data_in_ready and the stream)
//   slave  : the environment side (requests, read data, stream tready)
interface tx_header_fsm_if #(
  parameter int unsigned keep_width = 8
);

  logic                  cpl_start;
  logic                  cpl_busy;
  logic [2:0]            cpl_status;
  logic [9:0]            cpl_length;
  logic [15:0]           cpl_requester_id;
  logic [7:0]            cpl_tag;
  logic [6:0]            cpl_lower_addr;
  logic [15:0]           cpl_completer_id;

  logic [31:0]           data_in;
  logic                  data_in_valid;
  logic                  data_in_ready;

  logic [63:0]           tx_header_tdata;
  logic [keep_width-1:0] tx_header_tkeep;
  logic                  tx_header_tvalid;
  logic                  tx_header_tlast;
  logic                  tx_header_tready;

  modport master (
    input  cpl_start, cpl_status, cpl_length, cpl_requester_id, cpl_tag,
    input  cpl_lower_addr, cpl_completer_id,
    input  data_in, data_in_valid, tx_header_tready,
    output cpl_busy, data_in_ready,
    output tx_header_tdata, tx_header_tkeep, tx_header_tvalid, tx_header_tlast
  );

  modport slave (
    output cpl_start, cpl_status, cpl_length, cpl_requester_id, cpl_tag,
    output cpl_lower_addr, cpl_completer_id,
    output data_in, data_in_valid, tx_header_tready,
    input  cpl_busy, data_in_ready,
    input  tx_header_tdata, tx_header_tkeep, tx_header_tvalid, tx_header_tlast
  );

endinterface

// File: rtl/tx_header_fsm.sv
// Builds one PCIe completion TLP (Cpl or CplD) per cpl_start and streams it on
// a 64-bit AXI4-Stream bus. Header DWs and read-data DWs are packed two per
// beat, lower DW in tdata[31:0].
// Ports:
//   tx_header_clk   : clock, all logic on the rising edge
//   tx_header_reset : synchronous active-high reset
//   bus             : tx_header_fsm_if.master (request, data_in, stream)
module tx_header_fsm
  import tx_header_fsm_pkg::*;
#(
  parameter int unsigned keep_width = 8
) (
  input logic             tx_header_clk,
  input logic             tx_header_reset,
  tx_header_fsm_if.master bus
);

  localparam logic [keep_width-1:0] KeepFull = {keep_width{1'b1}};
  localparam logic [keep_width-1:0] KeepLow  =
      {{(keep_width - keep_width / 2){1'b0}}, {(keep_width / 2){1'b1}}};

  tx_state_e             state_q, state_d;
  cpl_req_t              req_q, req_d, new_req;
  logic [63:0]           data_q, data_d;
  logic [keep_width-1:0] keep_q, keep_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [31:0]           lo_q, lo_d;
  logic [10:0]           rem_q, rem_d;

  logic                  busy;
  logic                  slot_free;
  logic                  is_cpld;
  logic                  data_ready;
  logic [10:0]           rem_first;

  assign busy      = (state_q != StIdle) | valid_q;
  // The output register can take a new beat this cycle.
  assign slot_free = ~valid_q | bus.tx_header_tready;
  assign is_cpld   = (req_q.status == SC);
  // DWs still owed after the first one rides with DW2.
  assign rem_first = len_eff(req_q.len) - 11'd1;

  assign new_req = '{
    status:       cpl_status_e'(bus.cpl_status),
    len:          bus.cpl_length,
    requester_id: bus.cpl_requester_id,
    tag:          bus.cpl_tag,
    lower_addr:   bus.cpl_lower_addr,
    completer_id: bus.cpl_completer_id
  };

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    data_d     = data_q;
    keep_d     = keep_q;
    last_d     = last_q;
    // An accepted beat drops tvalid unless a new beat is loaded below.
    valid_d    = valid_q & ~bus.tx_header_tready;
    lo_d       = lo_q;
    rem_d      = rem_q;
    data_ready = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.cpl_start && !busy) begin
          req_d   = new_req;
          data_d  = {hdr_dw1(new_req), hdr_dw0(new_req)};
          keep_d  = KeepFull;
          last_d  = 1'b0;
          valid_d = 1'b1;
          state_d = StHdr2;
        end
      end

      StHdr2: begin
        if (!is_cpld) begin
          if (slot_free) begin
            data_d  = {32'h0, hdr_dw2(req_q)};
            keep_d  = KeepLow;
            last_d  = 1'b1;
            valid_d = 1'b1;
            state_d = StIdle;
          end
        end else begin
          data_ready = slot_free;
          if (slot_free && bus.data_in_valid) begin
            data_d  = {bus.data_in, hdr_dw2(req_q)};
            keep_d  = KeepFull;
            valid_d = 1'b1;
            rem_d   = rem_first;
            if (rem_first == 11'd0) begin
              last_d  = 1'b1;
              state_d = StIdle;
            end else begin
              last_d  = 1'b0;
              state_d = StDataLo;
            end
          end
        end
      end

      // Capturing the low DW does not touch the output register, so it may
      // proceed even while the current beat is stalled.
      StDataLo: begin
        data_ready = 1'b1;
        if (bus.data_in_valid) begin
          lo_d    = bus.data_in;
          state_d = (rem_q == 11'd1) ? StDataOdd : StDataHi;
        end
      end

      StDataHi: begin
        data_ready = slot_free;
        if (slot_free && bus.data_in_valid) begin
          data_d  = {bus.data_in, lo_q};
          keep_d  = KeepFull;
          valid_d = 1'b1;
          rem_d   = rem_q - 11'd2;
          if (rem_q == 11'd2) begin
            last_d  = 1'b1;
            state_d = StIdle;
          end else begin
            last_d  = 1'b0;
            state_d = StDataLo;
          end
        end
      end

      StDataOdd: begin
        if (slot_free) begin
          data_d  = {32'h0, lo_q};
          keep_d  = KeepLow;
          last_d  = 1'b1;
          valid_d = 1'b1;
          rem_d   = 11'd0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge tx_header_clk) begin
    if (tx_header_reset) begin
      state_q <= StIdle;
      req_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      lo_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.cpl_busy         = busy;
  assign bus.data_in_ready    = data_ready;
  assign bus.tx_header_tdata  = data_q;
  assign bus.tx_header_tkeep  = keep_q;
  assign bus.tx_header_tvalid = valid_q;
  assign bus.tx_header_tlast  = last_q;

endmodule

// File: doc/tx_header_fsm.md
TX_HEADER_FSM -- requirements
Module: tx_header_fsm

Interface
REQ-001 Parameter: keep_width, 8, tkeep width of the 64-bit AXI-4 Stream bus.
REQ-002 tx_header_clk  in  1  single clock; all logic on its rising edge.
REQ-003 tx_header_reset  in  1  synchronous, active-high reset.
REQ-004 cpl_start  in  1  one-cycle request to build one completion TLP.
REQ-005 cpl_busy  out  1  high while the FSM is not IDLE or tx_header_tvalid is high.
REQ-006 cpl_status  in  3  completion status; 000 (SC) gives CplD, any other value gives Cpl (no data).
REQ-007 cpl_length  in  10  payload length in DW; 0 encodes 1024.
REQ-008 cpl_requester_id  in  16  requester ID of the original request.
REQ-009 cpl_tag  in  8  tag of the original request.
REQ-010 cpl_lower_addr  in  7  lower address field.
REQ-011 cpl_completer_id  in  16  this function's ID.
REQ-012 data_in  in  32  read-response DW from the OCP side.
REQ-013 data_in_valid / data_in_ready  in / out  1 each  DW handshake; transfer when both are high.
REQ-014 tx_header_tdata / tx_header_tkeep  out  64 / keep_width  stream beat and byte enables.
REQ-015 tx_header_tvalid / tx_header_tlast  out  1 each  beat valid and end of packet.
REQ-016 tx_header_tready  in  1  core accepts the beat when tvalid and tready are both high.

Function
REQ-017 The FSM SHALL use states IDLE, HDR2, DATA_LO, DATA_HI and DATA_ODD; "slot free" means !tvalid | tready.
REQ-018 In IDLE with cpl_start and !cpl_busy, the FSM SHALL latch all cpl_* inputs, load beat0 = {DW1, DW0} with tkeep 8'hFF, and go to HDR2; tvalid SHALL rise on the next cycle (latency 1). cpl_start SHALL be ignored while busy.
REQ-019 DW0 SHALL be [31:24] = 8'h4A (CplD) or 8'h0A (Cpl), with TC, attr, TD and EP all 0, and [9:0] = cpl_length for CplD or 0 for Cpl.
REQ-020 DW1 SHALL be {completer_id, status, BCM=0, byte_count}, where byte_count = (len_eff*4 - lower_addr[1:0]) truncated to 12 bits, so 4096 encodes as 0.
REQ-021 DW2 SHALL be {requester_id, tag, 1'b0, lower_addr}; a DW sits in tdata[31:0] when it is the lower half of a beat.
REQ-022 HDR2, Cpl case: when slot free, the FSM SHALL load {32'b0, DW2} with tkeep 8'h0F and tlast, then go to IDLE.
REQ-023 HDR2, CplD case: data_in_ready SHALL equal slot free; on a handshake the FSM SHALL load {data_in, DW2} with tkeep 8'hFF and set remaining = len_eff-1 (11 bits).
  - If remaining is 0, the beat SHALL carry tlast and the FSM goes to IDLE.
  - Otherwise the FSM goes to DATA_LO.
REQ-024 DATA_LO: data_in_ready SHALL be 1; on a handshake the FSM SHALL capture lo_q; it goes to DATA_ODD if remaining==1, else to DATA_HI.
REQ-025 DATA_HI: data_in_ready SHALL equal slot free; on a handshake the FSM SHALL load {data_in, lo_q} with tkeep 8'hFF and subtract 2 from remaining.
  - If remaining was 2, the beat SHALL carry tlast and the FSM goes to IDLE.
  - Otherwise the FSM goes to DATA_LO.
REQ-026 DATA_ODD: when slot free, the FSM SHALL load {32'b0, lo_q} with tkeep 8'h0F and tlast, then go to IDLE.
REQ-027 While tvalid is high and tready is low, tdata, tkeep and tlast SHALL hold stable and tvalid SHALL stay high; in that state data_in_ready SHALL be 0 except in DATA_LO.
REQ-028 When the final beat is accepted (tvalid & tready & tlast) and no new beat is loaded that cycle, tvalid SHALL fall on the next cycle.
REQ-029 data_in_ready SHALL be 0 in IDLE and for Cpl packets; DWs beyond cpl_length SHALL never be consumed.

Reset
REQ-030 When tx_header_reset is high at a clock edge, the FSM SHALL return to IDLE and all of the following SHALL clear to 0: tvalid, tlast, tdata, tkeep, data_in_ready, cpl_busy, lo_q, remaining, latched fields.
REQ-031 A reset mid-packet SHALL abandon the packet without emitting tlast; the next cpl_start after reset SHALL build a fresh packet.

Structure
REQ-032 The shared package SHALL hold the state encodings, the fmt/type constants (CPL = 8'h0A, CPLD = 8'h4A) and the status codes (SC, UR, CA); it is shared with rx_header_fsm.
REQ-033 The block SHALL be a single module with no sub-modules; the header DW assembly is natural as a function in the package.

Verification
REQ-034 Scenario 1: CplD with len=1, req 0x0100, tag 0x05, lower 0x04, cmpl 0x0200, data 0xDEADBEEF, tready=1 -> 0x02000004_4A000001 (keep FF), then 0xDEADBEEF_01000504 (keep FF, tlast).
REQ-035 Scenario 2: len=4, data D0..D3 -> beats {DW1,DW0}, {D0,DW2}, {D2,D1}, {0,D3} with keep 0F and tlast; byte_count field = 0x010.
REQ-036 Scenario 3: status=001, len=1 -> beats 0x02002004_0A000000, then {0,DW2} with keep 0F and tlast; data_in_ready never high.
REQ-037 Scenario 4: tready low for 3 cycles on each beat of Scenario 2, plus a cpl_start pulsed mid-packet -> beats stable, no DW lost or duplicated, the extra start ignored.
REQ-038 Scenario 5: len=0 -> 514 beats, byte_count field 0, last beat keep 0F; reset asserted at beat 10 -> tvalid=0 the next cycle, and a following len=1 request completes correctly.
